hit_pair_issue: RTL and testbench
=================================

Name: hit_pair_issue

Overview:
- Transmitter side of the raster-to-zbuffer hit interface.
- Buffers single-lane sample hits from sample test (R17) in a small FIFO and drives the dual-lane zbuffer input (R18): hit_R18S/hit_R18S_2, shared color_R18U, hit_valid_R18H/hit_valid_R18H_2.
- Because both lanes share one color bus, two hits are paired only when their colors match.
- Lane 1 is always the older hit. The zbuffer processes lane 1 before lane 2, so program order is preserved.

Parameters:
- SIGFIG, 24, bits in position, depth and color words
- RADIX, 10, fraction bits in position
- AXIS, 3, axes per hit (x, y, z)
- COLORS, 3, color channels
- DEPTH, 4, FIFO entries; power of two, at least 2
- DEPTH_L2, 2, log2(DEPTH)

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-low
- hit_R17S  in  AXIS x SIGFIG signed  incoming hit x, y, z
- color_R17U  in  COLORS x SIGFIG unsigned  incoming hit color
- hit_valid_R17H  in  1  incoming hit valid
- halt_R17L  out  1  upstream backpressure; low means the hit is not accepted
- halt_RnnnnL  in  1  downstream stall; low means issue nothing
- hit_R18S  out  AXIS x SIGFIG signed  lane 1 hit
- hit_R18S_2  out  AXIS x SIGFIG signed  lane 2 hit
- color_R18U  out  COLORS x SIGFIG unsigned  color shared by both lanes
- hit_valid_R18H  out  1  lane 1 valid
- hit_valid_R18H_2  out  1  lane 2 valid
- fifo_cnt_RnnnnU  out  DEPTH_L2+1  current occupancy
- pair_cnt_RnnnnU  out  32  number of paired issues

Behaviour:
- Reset (rst low, asynchronous):
  - FIFO pointers, occupancy, all output registers and pair_cnt clear to 0.
  - halt_R17L is forced low while rst is low.
  - Effect is immediate, mid-operation included; buffered hits are discarded.
- Accept:
  - A hit is written on the clk edge where hit_valid_R17H=1 and halt_R17L=1.
  - halt_R17L = (fifo_cnt < DEPTH), combinational from the registered count.
  - No fall-through: a full FIFO keeps halt_R17L low even in a cycle that pops.
- Issue decision (combinational on FIFO head; registered at the edge):
  - halt_RnnnnL=0 or cnt=0: pop 0. Next edge sets both valids to 0; hit and color registers hold. A stall never repeats a hit.
  - cnt=1: pop 1. Lane 1 = head, lane 2 valid=0, hit_R18S_2 = 0.
  - cnt>=2 and every color channel of head equals head+1: pop 2. Lane 1 = head, lane 2 = head+1, color = head color, pair_cnt increments.
  - cnt>=2 with colors differing: pop 1, same as the cnt=1 case.
- Latency: a hit accepted at edge N appears on R18 after edge N+1 if halt_RnnnnL is high during cycle N+1. Sustained throughput is 1 accepted hit per cycle.
- Occupancy: a push and pop(s) in the same edge update it as cnt + push − pop.
  - Pointers are DEPTH_L2+1 bits with MSB wrap.
  - Full = cnt==DEPTH; empty = cnt==0.
  - pop never exceeds cnt.
- pair_cnt wraps modulo 2^32.
- Depth and position bits pass through unmodified; no rescaling or clipping.
- Integrity: no hit is lost, duplicated or reordered across any sequence of stalls.

Decomposition:
- Package zbuff_pkg holds SIGFIG, RADIX, AXIS and COLORS, plus typedef hit_entry_t: struct of hit[AXIS] signed and color[COLORS] unsigned.
- Sub-module hit_fifo: synchronous FIFO of hit_entry_t with async active-low reset, one push port, peek of head and head+1, pop amount 0/1/2, count output.
- hit_pair_issue adds the pairing compare, output registers and counter.

Test Plan:
- Reset: drive rst=0 with hit_valid_R17H=1 → all outputs 0 and halt_R17L=0; release rst → halt_R17L=1, fifo_cnt=0.
- Pairing: while halt_RnnnnL=0, accept hits A(x=0x00A400, y=0x001C00, z=0x000100, color=0xFFF,0,0) then B (same color, x=0x00A800) → cnt=2; raise halt_RnnnnL → next edge gives both valids=1, lane 1=A, lane 2=B, pair_cnt=1, cnt=0.
- Color split: back-to-back hits with color 0xFFF,0,0 then 0,0xFFF,0 → two consecutive single-lane issues in order, hit_valid_R18H_2 stays 0, pair_cnt unchanged.
- Backpressure: halt_RnnnnL=0 for 6 cycles with continuous valid input → cnt reaches 4, halt_R17L=0, no valids; release → drained in FIFO order as pairs where colors match, no loss or duplication (scoreboard).
- Async reset mid-drain: assert rst between edges with cnt=3 → valids and cnt 0 immediately, before the next edge; the old hits never appear.
- Lone hit: single accepted hit with halt_RnnnnL=1 → hit_valid_R18H=1 exactly one cycle, after edge N+1; hit_R18S_2=0.

Source files
------------

// File: rtl/zbuff_pkg.sv
// zbuff_pkg: shared widths and hit entry type for the raster-to-zbuffer path
package zbuff_pkg;
    localparam int SIGFIG = 24;
    localparam int RADIX = 10;
    localparam int AXIS = 3;
    localparam int COLORS = 3;
    typedef logic signed [SIGFIG-1:0] sig_t;
    typedef logic [SIGFIG-1:0] uns_t;
    typedef struct packed {
        sig_t [AXIS-1:0] hit;
        uns_t [COLORS-1:0] color;
    } hit_entry_t;
endpackage

// File: rtl/hit_pair_issue_fifo.sv
// hit_fifo: hit entry FIFO with head/head+1 peek and a 0/1/2 entry pop
module hit_fifo
    import zbuff_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DEPTH_L2 = 2
) (
    input logic clk,
    input logic rst,
    input logic push,
    input hit_entry_t din,
    input logic [1:0] pop,
    output hit_entry_t head,
    output hit_entry_t head_1,
    output logic [DEPTH_L2:0] cnt
);
    localparam int PW = DEPTH_L2 + 1;
    hit_entry_t mem [DEPTH];
    logic [DEPTH_L2:0] wr_ptr, rd_ptr, rd_nxt;
    assign rd_nxt = rd_ptr + PW'(1);
    assign head = mem[rd_ptr[DEPTH_L2-1:0]];
    assign head_1 = mem[rd_nxt[DEPTH_L2-1:0]];
    assign cnt = wr_ptr - rd_ptr;
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(push);
            rd_ptr <= rd_ptr + PW'(pop);
        end
    always_ff @(posedge clk)
        if (push) mem[wr_ptr[DEPTH_L2-1:0]] <= din;
endmodule

// File: rtl/hit_pair_issue.sv
// hit_pair_issue: buffers single-lane hits and issues same-color pairs on the dual-lane zbuffer input
module hit_pair_issue
    import zbuff_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DEPTH_L2 = 2
) (
    input logic clk,
    input logic rst,
    input logic signed [SIGFIG-1:0] hit_R17S [AXIS],
    input logic [SIGFIG-1:0] color_R17U [COLORS],
    input logic hit_valid_R17H,
    output logic halt_R17L,
    input logic halt_RnnnnL,
    output logic signed [SIGFIG-1:0] hit_R18S [AXIS],
    output logic signed [SIGFIG-1:0] hit_R18S_2 [AXIS],
    output logic [SIGFIG-1:0] color_R18U [COLORS],
    output logic hit_valid_R18H,
    output logic hit_valid_R18H_2,
    output logic [DEPTH_L2:0] fifo_cnt_RnnnnU,
    output logic [31:0] pair_cnt_RnnnnU
);
    localparam logic [DEPTH_L2:0] FULL = (DEPTH_L2+1)'(DEPTH);
    localparam logic [DEPTH_L2:0] ONE = (DEPTH_L2+1)'(1);
    hit_entry_t din, head, head_1;
    logic push;
    logic [1:0] pop;
    always_comb begin
        din = '0;
        for (int i = 0; i < AXIS; i++) din.hit[i] = hit_R17S[i];
        for (int i = 0; i < COLORS; i++) din.color[i] = color_R17U[i];
    end
    assign halt_R17L = rst && fifo_cnt_RnnnnU < FULL;
    assign push = hit_valid_R17H && halt_R17L;
    // the shared color bus only allows pairing when every channel matches
    assign pop = !halt_RnnnnL || fifo_cnt_RnnnnU == '0 ? 2'd0 :
                 fifo_cnt_RnnnnU > ONE && head.color == head_1.color ? 2'd2 : 2'd1;
    hit_fifo #(.DEPTH(DEPTH), .DEPTH_L2(DEPTH_L2)) u_fifo (
        .clk(clk),
        .rst(rst),
        .push(push),
        .din(din),
        .pop(pop),
        .head(head),
        .head_1(head_1),
        .cnt(fifo_cnt_RnnnnU)
    );
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            hit_R18S <= '{default: '0};
            hit_R18S_2 <= '{default: '0};
            color_R18U <= '{default: '0};
            hit_valid_R18H <= 1'b0;
            hit_valid_R18H_2 <= 1'b0;
            pair_cnt_RnnnnU <= '0;
        end else begin
            hit_valid_R18H <= pop != 2'd0;
            hit_valid_R18H_2 <= pop == 2'd2;
            if (pop != 2'd0) begin
                for (int i = 0; i < AXIS; i++) begin
                    hit_R18S[i] <= head.hit[i];
                    hit_R18S_2[i] <= pop == 2'd2 ? head_1.hit[i] : '0;
                end
                for (int i = 0; i < COLORS; i++) color_R18U[i] <= head.color[i];
            end
            if (pop == 2'd2) pair_cnt_RnnnnU <= pair_cnt_RnnnnU + 32'd1;
        end
endmodule

// File: tb/tb_hit_pair_issue.sv
// tb_hit_pair_issue: directed checks of pairing, color split, stalls and async reset
module tb_hit_pair_issue;
    import zbuff_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic signed [SIGFIG-1:0] hit_R17S [AXIS];
    logic [SIGFIG-1:0] color_R17U [COLORS];
    logic hit_valid_R17H = 1'b0;
    logic halt_RnnnnL = 1'b1;
    logic halt_R17L;
    logic signed [SIGFIG-1:0] hit_R18S [AXIS];
    logic signed [SIGFIG-1:0] hit_R18S_2 [AXIS];
    logic [SIGFIG-1:0] color_R18U [COLORS];
    logic hit_valid_R18H, hit_valid_R18H_2;
    logic [2:0] fifo_cnt_RnnnnU;
    logic [31:0] pair_cnt_RnnnnU;
    int checks = 0;
    int errors = 0;
    int issues, seen;
    logic [23:0] exp_x [$];
    always #5 clk = ~clk;
    hit_pair_issue dut (
        .clk(clk),
        .rst(rst),
        .hit_R17S(hit_R17S),
        .color_R17U(color_R17U),
        .hit_valid_R17H(hit_valid_R17H),
        .halt_R17L(halt_R17L),
        .halt_RnnnnL(halt_RnnnnL),
        .hit_R18S(hit_R18S),
        .hit_R18S_2(hit_R18S_2),
        .color_R18U(color_R18U),
        .hit_valid_R18H(hit_valid_R18H),
        .hit_valid_R18H_2(hit_valid_R18H_2),
        .fifo_cnt_RnnnnU(fifo_cnt_RnnnnU),
        .pair_cnt_RnnnnU(pair_cnt_RnnnnU)
    );
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic drive(input logic [23:0] x, input logic [1:0] col, input logic v);
        hit_R17S[0] = x;
        hit_R17S[1] = 24'h001C00;
        hit_R17S[2] = 24'h000100;
        for (int i = 0; i < COLORS; i++) color_R17U[i] = (i == int'(col)) ? 24'hFFF : 24'h0;
        hit_valid_R17H = v;
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
    initial begin
        drive(24'h00A400, 2'd0, 1'b1);
        repeat (2) tick;
        check("rst_v1", hit_valid_R18H, 0);
        check("rst_v2", hit_valid_R18H_2, 0);
        check("rst_halt", halt_R17L, 0);
        check("rst_cnt", fifo_cnt_RnnnnU, 0);
        check("rst_pair", pair_cnt_RnnnnU, 0);
        check("rst_hit", hit_R18S[0], 0);
        check("rst_color", color_R18U[0], 0);
        rst = 1'b1;
        hit_valid_R17H = 1'b0;
        #1;
        check("rel_halt", halt_R17L, 1);
        check("rel_cnt", fifo_cnt_RnnnnU, 0);
        halt_RnnnnL = 1'b0;
        drive(24'h00A400, 2'd0, 1'b1);
        tick;
        drive(24'h00A800, 2'd0, 1'b1);
        tick;
        check("pair_cnt2", fifo_cnt_RnnnnU, 2);
        check("pair_stall_v", hit_valid_R18H, 0);
        hit_valid_R17H = 1'b0;
        halt_RnnnnL = 1'b1;
        tick;
        check("pair_v1", hit_valid_R18H, 1);
        check("pair_v2", hit_valid_R18H_2, 1);
        check("pair_x", hit_R18S[0], 64'h00A400);
        check("pair_y", hit_R18S[1], 64'h001C00);
        check("pair_z", hit_R18S[2], 64'h000100);
        check("pair_x2", hit_R18S_2[0], 64'h00A800);
        check("pair_col", color_R18U[0], 64'hFFF);
        check("pair_pcnt", pair_cnt_RnnnnU, 1);
        check("pair_cnt0", fifo_cnt_RnnnnU, 0);
        tick;
        check("pair_off", hit_valid_R18H, 0);
        check("pair_hold", hit_R18S[0], 64'h00A400);
        halt_RnnnnL = 1'b0;
        drive(24'h000010, 2'd0, 1'b1);
        tick;
        drive(24'h000020, 2'd1, 1'b1);
        tick;
        hit_valid_R17H = 1'b0;
        halt_RnnnnL = 1'b1;
        tick;
        check("split1_v1", hit_valid_R18H, 1);
        check("split1_v2", hit_valid_R18H_2, 0);
        check("split1_x", hit_R18S[0], 64'h10);
        check("split1_l2", hit_R18S_2[0], 0);
        check("split1_col", color_R18U[0], 64'hFFF);
        check("split1_cnt", fifo_cnt_RnnnnU, 1);
        tick;
        check("split2_v1", hit_valid_R18H, 1);
        check("split2_v2", hit_valid_R18H_2, 0);
        check("split2_x", hit_R18S[0], 64'h20);
        check("split2_col0", color_R18U[0], 0);
        check("split2_col1", color_R18U[1], 64'hFFF);
        check("split2_pcnt", pair_cnt_RnnnnU, 1);
        tick;
        halt_RnnnnL = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive(24'(24'h100 + i), i < 2 ? 2'd0 : i == 2 ? 2'd1 : 2'd2, 1'b1);
            if (halt_R17L) exp_x.push_back(24'(24'h100 + i));
            tick;
        end
        check("bp_cnt", fifo_cnt_RnnnnU, 4);
        check("bp_halt", halt_R17L, 0);
        check("bp_v", hit_valid_R18H, 0);
        check("bp_acc", exp_x.size(), 4);
        hit_valid_R17H = 1'b0;
        halt_RnnnnL = 1'b1;
        issues = 0;
        for (int c = 0; c < 10; c++) begin
            tick;
            if (hit_valid_R18H) begin
                issues++;
                check("drain_l1", hit_R18S[0], exp_x.size() > 0 ? 64'(exp_x.pop_front()) : 64'hDEAD);
                if (hit_valid_R18H_2)
                    check("drain_l2", hit_R18S_2[0], exp_x.size() > 0 ? 64'(exp_x.pop_front()) : 64'hDEAD);
            end
        end
        check("drain_left", exp_x.size(), 0);
        check("drain_issues", issues, 3);
        check("drain_pcnt", pair_cnt_RnnnnU, 2);
        halt_RnnnnL = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(24'(24'h200 + i), 2'(i % 3), 1'b1);
            tick;
        end
        hit_valid_R17H = 1'b0;
        halt_RnnnnL = 1'b1;
        tick;
        check("ar_pre_v", hit_valid_R18H, 1);
        check("ar_pre_x", hit_R18S[0], 64'h200);
        check("ar_pre_cnt", fifo_cnt_RnnnnU, 3);
        #2 rst = 1'b0;
        #1;
        check("ar_v", hit_valid_R18H, 0);
        check("ar_cnt", fifo_cnt_RnnnnU, 0);
        check("ar_halt", halt_R17L, 0);
        check("ar_pcnt", pair_cnt_RnnnnU, 0);
        #2 rst = 1'b1;
        seen = 0;
        repeat (5) begin
            tick;
            if (hit_valid_R18H || hit_valid_R18H_2) seen++;
        end
        check("ar_stale", seen, 0);
        drive(24'h00ABCD, 2'd1, 1'b1);
        tick;
        hit_valid_R17H = 1'b0;
        check("lone_n_v", hit_valid_R18H, 0);
        check("lone_n_cnt", fifo_cnt_RnnnnU, 1);
        tick;
        check("lone_v1", hit_valid_R18H, 1);
        check("lone_v2", hit_valid_R18H_2, 0);
        check("lone_x", hit_R18S[0], 64'h00ABCD);
        check("lone_l2", hit_R18S_2[0], 0);
        tick;
        check("lone_off", hit_valid_R18H, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
